// File: rtl/comb_fitness_eval.sv
// Truth-table harness: sweeps every input vector of a combinational candidate,
// captures its output table and counts mismatches against a latched target.
module comb_fitness_eval #(
    parameter int NUM_INPUTS    = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [(1<<NUM_INPUTS)-1:0]   target_tt,
    output logic [NUM_INPUTS-1:0]        dut_in,
    input  logic                         dut_out,
    output logic                         busy,
    output logic                         done,
    output logic [(1<<NUM_INPUTS)-1:0]   captured_tt,
    output logic [NUM_INPUTS:0]          mismatch_count
);

    localparam int TT_W = 1 << NUM_INPUTS;
    localparam logic [NUM_INPUTS-1:0] LAST_VEC = NUM_INPUTS'(TT_W - 1);
    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [TT_W-1:0]         target_q, target_d;
    logic [TT_W-1:0]         captured_q, captured_d;
    logic [NUM_INPUTS:0]     mismatch_q, mismatch_d;
    logic [NUM_INPUTS-1:0]   vec_q, vec_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        captured_d = captured_q;
        mismatch_d = mismatch_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    target_d   = target_tt;
                    captured_d = '0;
                    mismatch_d = '0;
                    vec_d      = '0;
                    cnt_d      = RELOAD;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    vec_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                // abort cancels this cycle's sample; partial results stay as they were
                if (abort) begin
                    vec_d   = '0;
                    state_d = IDLE;
                end else begin
                    captured_d[vec_q] = dut_out;
                    if (dut_out != target_q[vec_q]) begin
                        mismatch_d = mismatch_q + 1'b1;
                    end
                    if (vec_q == LAST_VEC) begin
                        state_d = DONE;
                    end else begin
                        vec_d   = vec_q + 1'b1;
                        cnt_d   = RELOAD;
                        state_d = SETTLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            target_q   <= '0;
            captured_q <= '0;
            mismatch_q <= '0;
            vec_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            captured_q <= captured_d;
            mismatch_q <= mismatch_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign dut_in         = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign captured_tt    = captured_q;
    assign mismatch_count = mismatch_q;

endmodule

// File: tb/tb_comb_fitness_eval.sv
// Bench for comb_fitness_eval: two instances (settle 1 and 3) driven by one
// stimulus stream, checked every cycle against a sweep-position model.
module tb_comb_fitness_eval;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] target_tt = '0;
    logic [15:0] fn_tt = '0;

    logic [3:0]  din_w  [2];
    logic        dout_w [2];
    logic        busy_w [2];
    logic        done_w [2];
    logic [15:0] cap_w  [2];
    logic [4:0]  mis_w  [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Candidate circuit under evaluation is a lookup of fn_tt.
    assign dout_w[0] = fn_tt[din_w[0]];
    assign dout_w[1] = fn_tt[din_w[1]];

    comb_fitness_eval #(.NUM_INPUTS(4), .SETTLE_CYCLES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .target_tt(target_tt), .dut_in(din_w[0]), .dut_out(dout_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .captured_tt(cap_w[0]),
        .mismatch_count(mis_w[0]));

    comb_fitness_eval #(.NUM_INPUTS(4), .SETTLE_CYCLES(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .target_tt(target_tt), .dut_in(din_w[1]), .dut_out(dout_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .captured_tt(cap_w[1]),
        .mismatch_count(mis_w[1]));

    // Model: edges elapsed since accept (m_t) fully determines every output.
    bit          m_act [2];
    bit          m_ab  [2];
    int          m_t   [2];
    logic [15:0] m_tgt [2];
    logic [15:0] m_fn  [2];

    function automatic int stl(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int per(input int i);
        return 16 * (stl(i) + 1);
    endfunction

    function automatic int nsamp(input int i);
        return m_t[i] / (stl(i) + 1);
    endfunction

    function automatic logic [15:0] mask_n(input int n);
        logic [16:0] m;
        m = (17'd1 << n) - 17'd1;
        return m[15:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_act[i] <= 1'b0;
                m_ab[i]  <= 1'b0;
                m_t[i]   <= 0;
                m_tgt[i] <= '0;
                m_fn[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_act[i]) begin
                    if (m_t[i] == per(i)) m_act[i] <= 1'b0;
                    else if (abort) begin
                        m_act[i] <= 1'b0;
                        m_ab[i]  <= 1'b1;
                    end else m_t[i] <= m_t[i] + 1;
                end else if (start) begin
                    m_act[i] <= 1'b1;
                    m_ab[i]  <= 1'b0;
                    m_t[i]   <= 0;
                    m_tgt[i] <= target_tt;
                    m_fn[i]  <= fn_tt;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (time %0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("busy[%0d]", i), 32'(busy_w[i]), 32'(m_act[i] && (m_t[i] < per(i))));
            chk($sformatf("done[%0d]", i), 32'(done_w[i]), 32'(m_act[i] && (m_t[i] == per(i))));
            chk($sformatf("dut_in[%0d]", i), 32'(din_w[i]),
                m_ab[i] ? 32'd0 : ((nsamp(i) > 15) ? 32'd15 : 32'(nsamp(i))));
            chk($sformatf("captured_tt[%0d]", i), 32'(cap_w[i]), 32'(m_fn[i] & mask_n(nsamp(i))));
            chk($sformatf("mismatch_count[%0d]", i), 32'(mis_w[i]),
                32'($countones((m_fn[i] ^ m_tgt[i]) & mask_n(nsamp(i)))));
        end
    end

    task automatic wait_idle();
        int k = 0;
        while ((m_act[0] || m_act[1]) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("idle_wait_bound", 32'(k < 200), 32'd1);
    endtask

    task automatic run_sweep(input logic [15:0] fn, input logic [15:0] tgt,
                             input logic [15:0] exp_cap, input logic [4:0] exp_mis,
                             input bit disturb);
        int acc, lat0, lat1, dones0;
        logic [15:0] cap0, cap1;
        logic [4:0]  mis0, mis1;
        lat0 = 0; lat1 = 0; dones0 = 0;
        cap0 = 'x; cap1 = 'x; mis0 = 'x; mis1 = 'x;
        wait_idle();
        @(negedge clk);
        fn_tt = fn;
        target_tt = tgt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = cyc;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (disturb && k == 10) begin
                start = 1'b1;
                target_tt = ~tgt;
            end else begin
                start = 1'b0;
            end
            if (done_w[0]) begin
                dones0++;
                lat0 = cyc - acc + 1;
                cap0 = cap_w[0];
                mis0 = mis_w[0];
            end
            if (done_w[1]) begin
                lat1 = cyc - acc + 1;
                cap1 = cap_w[1];
                mis1 = mis_w[1];
            end
        end
        chk("single_done", 32'(dones0), 32'd1);
        chk("latency_s1", 32'(lat0), 32'd33);
        chk("latency_s3", 32'(lat1), 32'd65);
        chk("final_cap_s1", 32'(cap0), 32'(exp_cap));
        chk("final_mis_s1", 32'(mis0), 32'(exp_mis));
        chk("final_cap_s3", 32'(cap1), 32'(exp_cap));
        chk("final_mis_s3", 32'(mis1), 32'(exp_mis));
    endtask

    initial begin
        int acc, dn;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy_w[0]), 32'd0);
        chk("reset_cap", 32'(cap_w[0]), 32'd0);
        chk("reset_mis", 32'(mis_w[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ~C&(D|A)&~(A&B) has ones at vectors 1, 8, 9, 10.
        run_sweep(16'h0702, 16'h0702, 16'h0702, 5'd0, 1'b0);
        run_sweep(16'h0702, 16'h0000, 16'h0702, 5'd4, 1'b0);
        run_sweep(16'h0702, 16'hFFFF, 16'h0702, 5'd12, 1'b0);
        run_sweep(16'h0000, 16'hFFFF, 16'h0000, 5'd16, 1'b0);
        run_sweep(16'h0702, 16'h0000, 16'h0702, 5'd4, 1'b1);

        // Abort mid-sweep.
        wait_idle();
        @(negedge clk);
        fn_tt = 16'h0702; target_tt = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = cyc;
        dn = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            abort = (k == 12);
            if (done_w[0] || done_w[1]) dn++;
            if (k == 13) begin
                chk("abort_busy", 32'(busy_w[0]), 32'd0);
                chk("abort_dut_in", 32'(din_w[0]), 32'd0);
            end
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        run_sweep(16'h0702, 16'h0000, 16'h0702, 5'd4, 1'b0);

        // Asynchronous reset between edges mid-sweep.
        wait_idle();
        @(negedge clk);
        fn_tt = 16'h0702; target_tt = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_w[0]), 32'd0);
        chk("arst_done", 32'(done_w[0]), 32'd0);
        chk("arst_dut_in", 32'(din_w[0]), 32'd0);
        chk("arst_cap", 32'(cap_w[0]), 32'd0);
        chk("arst_mis", 32'(mis_w[0]), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done_w[0] || done_w[1]) dn++;
        end
        chk("post_reset_no_done", 32'(dn), 32'd0);

        // Random traffic: starts, aborts, target churn; candidate changes only while idle.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 3) == 0) target_tt = 16'($urandom);
            if (!m_act[0] && !m_act[1] && $urandom_range(0, 3) == 0) fn_tt = 16'($urandom);
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (80) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
